// File: rtl/datapath_rtl_29.sv
// Register-transfer datapath: A/E accumulator with clear/load/increment/rotate micro-ops,
// a pass counter P, and a sticky flag that records overlapping A-group strobes.
module datapath_rtl_29 #(
    parameter int WIDTH  = 4,
    parameter int CNT_W  = 3,
    parameter int P_LAST = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             clr_a,
    input  logic             load_a,
    input  logic             incr_a,
    input  logic             shr_a,
    input  logic             clr_p,
    input  logic             inc_p,
    output logic [WIDTH-1:0] a,
    output logic             E,
    output logic             F,
    output logic             zero,
    output logic [CNT_W-1:0] p,
    output logic             p_done,
    output logic             conflict
);

    logic [WIDTH-1:0] a_q, a_d;
    logic             e_q, e_d;
    logic [CNT_W-1:0] p_q, p_d;
    logic             conflict_q, conflict_d;

    logic [WIDTH:0]   inc_sum;
    logic [2:0]       a_strobe_cnt;

    always_comb begin
        a_d        = a_q;
        e_d        = e_q;
        p_d        = p_q;
        conflict_d = conflict_q;
        inc_sum    = {1'b0, a_q} + (WIDTH+1)'(1);
        a_strobe_cnt = 3'({2'b00, clr_a}) + 3'({2'b00, load_a})
                     + 3'({2'b00, incr_a}) + 3'({2'b00, shr_a});

        // Fixed priority: only the highest-ranked A strobe executes.
        if (clr_a) begin
            a_d = '0;
            e_d = 1'b0;
        end else if (load_a) begin
            a_d = din;
        end else if (incr_a) begin
            a_d = inc_sum[WIDTH-1:0];
            e_d = inc_sum[WIDTH];
        end else if (shr_a) begin
            a_d = {e_q, a_q[WIDTH-1:1]};
            e_d = a_q[0];
        end

        if (a_strobe_cnt > 3'd1) begin
            conflict_d = 1'b1;
        end

        // clr_p together with inc_p is a legal combination and is not a conflict.
        if (clr_p) begin
            p_d = '0;
        end else if (inc_p) begin
            p_d = p_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            a_q        <= '0;
            e_q        <= 1'b0;
            p_q        <= '0;
            conflict_q <= 1'b0;
        end else begin
            a_q        <= a_d;
            e_q        <= e_d;
            p_q        <= p_d;
            conflict_q <= conflict_d;
        end
    end

    assign a        = a_q;
    assign E        = e_q;
    assign F        = a_q[WIDTH-1];
    assign zero     = (a_q == '0);
    assign p        = p_q;
    assign p_done   = (p_q == CNT_W'(P_LAST));
    assign conflict = conflict_q;

endmodule

// File: tb/tb_datapath_rtl_29.sv
// Self-checking bench for datapath_rtl_29: directed scenarios followed by randomized
// micro-op streams with occasional mid-cycle resets, all compared against an arithmetic model.
module tb_datapath_rtl_29;

    localparam int WIDTH  = 4;
    localparam int CNT_W  = 3;
    localparam int P_LAST = 5;
    localparam int A_MOD  = 1 << WIDTH;
    localparam int P_MOD  = 1 << CNT_W;

    logic             clock;
    logic             reset;
    logic [WIDTH-1:0] din;
    logic             clr_a, load_a, incr_a, shr_a, clr_p, inc_p;
    logic [WIDTH-1:0] a;
    logic             E, F, zero;
    logic [CNT_W-1:0] p;
    logic             p_done, conflict;

    int checks;
    int errors;

    // Reference state kept as plain integers.
    int m_a, m_e, m_p, m_conf;

    datapath_rtl_29 #(.WIDTH(WIDTH), .CNT_W(CNT_W), .P_LAST(P_LAST)) dut (
        .clock    (clock),
        .reset    (reset),
        .din      (din),
        .clr_a    (clr_a),
        .load_a   (load_a),
        .incr_a   (incr_a),
        .shr_a    (shr_a),
        .clr_p    (clr_p),
        .inc_p    (inc_p),
        .a        (a),
        .E        (E),
        .F        (F),
        .zero     (zero),
        .p        (p),
        .p_done   (p_done),
        .conflict (conflict)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h t=%0t", tag, observed, expected, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".a"},        32'(a),        32'(m_a));
        check({tag, ".E"},        32'(E),        32'(m_e));
        check({tag, ".F"},        32'(F),        32'((m_a >> (WIDTH-1)) & 1));
        check({tag, ".zero"},     32'(zero),     32'(m_a == 0));
        check({tag, ".p"},        32'(p),        32'(m_p));
        check({tag, ".p_done"},   32'(p_done),   32'(m_p == P_LAST));
        check({tag, ".conflict"}, 32'(conflict), 32'(m_conf));
    endtask

    task automatic model_reset();
        m_a = 0; m_e = 0; m_p = 0; m_conf = 0;
    endtask

    // Behavioural effect of one clock edge; E:A and A:E are treated as integers.
    task automatic model_edge(input int ca, input int la, input int ia, input int sa,
                              input int cp, input int ip, input int d);
        int s, r;
        if (ca + la + ia + sa > 1) m_conf = 1;
        if (ca != 0) begin
            m_a = 0; m_e = 0;
        end else if (la != 0) begin
            m_a = d;
        end else if (ia != 0) begin
            s   = m_a + 1;
            m_a = s % A_MOD;
            m_e = s / A_MOD;
        end else if (sa != 0) begin
            r   = m_a * 2 + m_e;
            r   = (r >> 1) + (r % 2) * A_MOD;
            m_a = r / 2;
            m_e = r % 2;
        end
        if (cp != 0)      m_p = 0;
        else if (ip != 0) m_p = (m_p + 1) % P_MOD;
    endtask

    // Called at a negedge: drive strobes, take one edge, check, return at the next negedge.
    task automatic cycle(input string tag, input logic ca, input logic la, input logic ia,
                         input logic sa, input logic cp, input logic ip, input logic [WIDTH-1:0] d);
        clr_a = ca; load_a = la; incr_a = ia; shr_a = sa; clr_p = cp; inc_p = ip; din = d;
        @(posedge clock);
        model_edge(int'(ca), int'(la), int'(ia), int'(sa), int'(cp), int'(ip), int'(d));
        #1;
        check_all(tag);
        @(negedge clock);
        {clr_a, load_a, incr_a, shr_a, clr_p, inc_p} = '0;
    endtask

    // Reset asserted between edges: must clear at once and hold through an edge.
    task automatic async_reset(input string tag);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_all({tag, ".imm"});
        @(posedge clock);
        #1;
        check_all({tag, ".held"});
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        model_reset();
        reset = 1'b1;
        din = '0;
        {clr_a, load_a, incr_a, shr_a, clr_p, inc_p} = '0;

        #100;
        reset = 1'b0;
        #1;
        check_all("reset");
        @(negedge clock);

        cycle("load1010", 0, 1, 0, 0, 0, 0, 4'b1010);
        cycle("shr0101",  0, 0, 0, 1, 0, 0, 4'b0000);

        cycle("loadF",    0, 1, 0, 0, 0, 0, 4'hF);
        cycle("incr_wrap",0, 0, 1, 0, 0, 0, 4'h0);
        cycle("shr1000",  0, 0, 0, 1, 0, 0, 4'h0);
        cycle("incr_noc", 0, 0, 1, 0, 0, 0, 4'h0);

        cycle("clr_p",    0, 0, 0, 0, 1, 0, 4'h0);
        for (int i = 0; i < 8; i++) cycle("inc_p", 0, 0, 0, 0, 0, 1, 4'h0);
        cycle("clr_inc_p",0, 0, 0, 0, 1, 1, 4'h0);

        cycle("load_incr",0, 1, 1, 0, 0, 0, 4'd3);
        cycle("clr_a",    1, 0, 0, 0, 0, 0, 4'd0);
        cycle("idle",     0, 0, 0, 0, 0, 0, 4'd9);
        async_reset("rst_conf");

        cycle("clr_a2",   1, 0, 0, 0, 1, 0, 4'd0);
        for (int i = 0; i < 7; i++) cycle("incr_run", 0, 0, 1, 0, 0, 1, 4'd0);
        incr_a = 1'b1;
        async_reset("rst_mid");
        cycle("incr_after", 0, 0, 1, 0, 0, 0, 4'd0);

        for (int i = 0; i < 400; i++) begin
            logic [5:0] s;
            logic [WIDTH-1:0] d;
            d = WIDTH'($urandom_range(0, A_MOD - 1));
            if ($urandom_range(0, 3) == 0) begin
                s = 6'($urandom_range(0, 63));
            end else begin
                s = '0;
                s[$urandom_range(0, 5)] = 1'b1;
                if ($urandom_range(0, 5) == 0) s = '0;
            end
            cycle("rand", s[5], s[4], s[3], s[2], s[1], s[0], d);
            if (i % 60 == 59) async_reset("rand_rst");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "bench did not finish");
    end

endmodule
